// File: rtl/rv523_regfile_pkg.sv
// Shared constants and word type for the RV523 register bank.
package rv523_regfile_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int ZERO_ADDR = 0;

  typedef logic [DEF_WIDTH-1:0] word_t;
endpackage

// File: rtl/latch_dff_word.sv
// One register word built from master/slave latch pairs: rising-edge capture, load-gated, synchronous clear.
// Master follows D (or 0 in reset) while CLK is low; the slave opens during the high phase only if a load was latched.
import rv523_regfile_pkg::*;

module latch_dff_word #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] D,
  input  logic             CLK,
  input  logic             nCLK,
  input  logic             LOAD,
  input  logic             nRST,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] master;
  logic             load_held;

  // Load is held through the high phase so the slave enable cannot glitch.
  always_latch begin
    if (nCLK) begin
      master    <= nRST ? D : '0;
      load_held <= LOAD | ~nRST;
    end
  end

  always_latch begin
    if (CLK && load_held) begin
      Q <= master;
    end
  end

endmodule

// File: rtl/latch_regfile.sv
// Register bank, word 0 reads as zero; 1 sync write port, 2 combinational reads.
// Optional write-through forwarding under macro LATCH_REGFILE_BYPASS_EN.
import rv523_regfile_pkg::*;

module latch_regfile #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             WE,
  input  logic [AW-1:0]    WADDR,
  input  logic [WIDTH-1:0] WDATA,
  input  logic [AW-1:0]    RADDR1,
  output logic [WIDTH-1:0] RDATA1,
  input  logic [AW-1:0]    RADDR2,
  output logic [WIDTH-1:0] RDATA2
);

  // Every encodable address gets a slot; x0 and out-of-range slots are tied to zero.
  localparam int NSLOT = 1 << AW;

  logic [WIDTH-1:0] words [NSLOT];

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    if (i == ZERO_ADDR || i >= DEPTH) begin : g_zero
      assign words[i] = '0;
    end else begin : g_word
      logic nclk;
      logic load;

      assign nclk = ~CLK;
      assign load = WE && (WADDR == AW'(i));

      latch_dff_word #(.WIDTH(WIDTH)) u_word (
        .D    (WDATA),
        .CLK  (CLK),
        .nCLK (nclk),
        .LOAD (load),
        .nRST (nRST),
        .Q    (words[i])
      );
    end
  end

`ifdef LATCH_REGFILE_BYPASS_EN
  logic [NSLOT-1:0] fwd_ok;
  logic             wr_live;

  for (genvar i = 0; i < NSLOT; i++) begin : g_fwd
    assign fwd_ok[i] = (i != ZERO_ADDR) && (i < DEPTH);
  end

  assign wr_live = WE && nRST && fwd_ok[WADDR];
  assign RDATA1  = (wr_live && RADDR1 == WADDR) ? WDATA : words[RADDR1];
  assign RDATA2  = (wr_live && RADDR2 == WADDR) ? WDATA : words[RADDR2];
`else
  assign RDATA1 = words[RADDR1];
  assign RDATA2 = words[RADDR2];
`endif

endmodule
